// File: rtl/serial_addsub_pkg.sv
// Shared types and helpers for the bit-serial add/subtract accumulator.
package serial_addsub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit conditional-invert full adder, reused serially by the accumulator.
module addsub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  output logic sum_c,
  output logic carry_c
);

  logic b_eff;

  assign b_eff   = b ^ sub;
  assign sum_c   = a ^ b_eff ^ cin;
  assign carry_c = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule

// File: rtl/serial_addsub_accum.sv
// Bit-serial add/subtract accumulator, LSB first, one bit per clock.
// Define ACCUM_SAT_EN to clamp the committed result on signed overflow.
module serial_addsub_accum
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             sub,
  input  logic             clear,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned     CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             sub_q;
  logic             c;
  logic             sum_bit;
  logic             carry_bit;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] commit_c;
  logic             ovf_c;

  addsub_bit_cell u_cell (
    .a       (a_sr[0]),
    .b       (b_sr[0]),
    .sub     (sub_q),
    .cin     (c),
    .sum_c   (sum_bit),
    .carry_c (carry_bit)
  );

  assign in_ready = (state == IDLE) && !clear;

  // A drains out of the bottom while sum bits fill in from the top, so the
  // A register doubles as the result register.
  assign res_c = {sum_bit, a_sr[WIDTH-1:1]};

  // On the last step c is the carry into the MSB and carry_bit the carry out.
  assign ovf_c = c ^ carry_bit;

`ifdef ACCUM_SAT_EN
  // On overflow both addends share a sign, so A's MSB picks the clamp rail.
  always_comb begin
    commit_c = res_c;
    if (ovf_c) begin
      commit_c = a_sr[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign commit_c = res_c;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      sub_q     <= 1'b0;
      c         <= 1'b0;
      acc_out   <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            acc_out  <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b1;
          end else if (in_valid) begin
            a_sr  <= acc_out;
            b_sr  <= operand;
            sub_q <= sub;
            c     <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr <= res_c;
          b_sr <= b_sr >> 1;
          c    <= carry_bit;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            acc_out   <= commit_c;
            carry     <= carry_bit;
            overflow  <= ovf_c;
            zero      <= (commit_c == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
